fetch_controller: RTL

Host-facing sequencer for the instruction fetch stage. Accepts a byte-wide command stream and loads program words into instruction memory. Drives the fetch stage's stall and PC-reset inputs to run a program to completion, single-step it, or halt it. Sits between the UART/debug receiver and `instruction_fetch`.

---
 rtl/fetch_ctrl_pkg.sv | 21 ++
 rtl/word_assembler.sv | 57 +++++
 rtl/fetch_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: host command bytes and FSM state encoding.
package fetch_ctrl_pkg;

  // Host command bytes (ASCII).
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

  // Encoding is visible on o_state, so values are pinned explicitly.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLdCount = 3'd1,
    StLdData  = 3'd2,
    StResetPc = 3'd3,
    StRun     = 3'd4,
    StStep    = 3'd5,
    StDone    = 3'd6
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream MSB-first into SIZE-bit words; pulses o_word_valid for one cycle
// after the byte that completes a word.
module word_assembler #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_byte_last,
  output logic            o_word_valid,
  output logic [SIZE-1:0] o_word
);

  localparam int unsigned Bytes = SIZE / 8;
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Bytes - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] word_q, word_d;
  logic            valid_q, valid_d;

  // Combinational look-ahead: the byte being offered right now completes a word.
  assign o_byte_last  = i_byte_valid && (cnt_q == LastCnt);
  assign o_word_valid = valid_q;
  assign o_word       = word_q;

  // Next-state: clear has priority over a byte; the counter wraps after the last byte.
  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (i_clr) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (i_byte_valid) begin
      word_d  = (word_q << 8) | SIZE'(i_byte);
      cnt_d   = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
      valid_d = (cnt_q == LastCnt);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Host-facing sequencer for the instruction fetch stage: loads program words from a byte
// command stream and drives the fetch stage's stall / PC-reset to run, step or halt.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter  int unsigned SIZE            = 32,
  parameter  int unsigned MAX_INSTRUCTION = 9,
  localparam int unsigned ADDR_W          = $clog2(MAX_INSTRUCTION)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  input  logic [7:0]        i_cmd_data,
  output logic              o_cmd_ready,
  input  logic [SIZE-1:0]   i_pc,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]   o_imem_wdata,
  output logic              o_stall,
  output logic              o_fetch_rst,
  output logic [2:0]        o_state,
  output logic [ADDR_W:0]   o_loaded_count
);

  localparam int unsigned CntW = ADDR_W + 1;

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;         // where RESET_PC goes next
  logic [CntW-1:0]   count_q, count_d;     // word count of the load in progress
  logic [ADDR_W-1:0] widx_q, widx_d;       // index of the word being assembled
  logic [CntW-1:0]   loaded_q, loaded_d;   // committed count of the last complete load
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fetch_rst_q, fetch_rst_d;
  logic              live_q;               // low until the first edge after reset release

  logic              accept;
  logic              asm_clr;
  logic              asm_valid;
  logic              asm_last;
  logic              asm_word_valid;
  logic [SIZE-1:0]   asm_word;
  logic [SIZE-1:0]   last_pc;
  logic              at_last;
  logic              count_ok;
  logic              last_word;

  assign accept    = i_cmd_valid && o_cmd_ready;
  assign asm_clr   = accept && (state_q == StLdCount);
  assign asm_valid = accept && (state_q == StLdData);

  word_assembler #(
    .SIZE (SIZE)
  ) u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (asm_clr),
    .i_byte_valid (asm_valid),
    .i_byte       (i_cmd_data),
    .o_byte_last  (asm_last),
    .o_word_valid (asm_word_valid),
    .o_word       (asm_word)
  );

  // RUN is only entered with a nonzero load, so last_pc never underflows there.
  assign last_pc   = SIZE'(loaded_q) - SIZE'(1);
  assign at_last   = !(i_pc < last_pc);
  assign count_ok  = (i_cmd_data != 8'd0) && (32'(i_cmd_data) <= MAX_INSTRUCTION);
  assign last_word = ({1'b0, widx_q} == (count_q - CntW'(1)));

  // Controller next-state logic and registered-output next values.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    count_d  = count_q;
    widx_d   = widx_q;
    loaded_d = loaded_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          case (i_cmd_data)
            CMD_LOAD: state_d = StLdCount;
            CMD_RUN: begin
              if (loaded_q != '0) begin
                state_d = StResetPc;
                ret_d   = StRun;
              end
            end
            CMD_STEP: begin
              if ((state_q == StIdle) && (loaded_q != '0)) state_d = StStep;
            end
            default: ;  // HALT is a no-op here; unknown codes are dropped
          endcase
        end
      end
      StLdCount: begin
        if (accept) begin
          if (count_ok) begin
            count_d = CntW'(i_cmd_data);
            widx_d  = '0;
            state_d = StLdData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLdData: begin
        if (asm_last) begin
          we_d   = 1'b1;
          addr_d = widx_q;
          widx_d = widx_q + ADDR_W'(1);
          if (last_word) begin
            loaded_d = count_q;
            state_d  = StResetPc;
            ret_d    = StIdle;
          end
        end
      end
      StResetPc: state_d = ret_q;
      StRun: begin
        // Halt takes priority over reaching the last PC in the same cycle.
        if (accept && (i_cmd_data == CMD_HALT)) state_d = StIdle;
        else if (at_last)                       state_d = StDone;
      end
      StStep:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The fetch reset is high exactly for the cycle spent in RESET_PC.
  assign fetch_rst_d = (state_d == StResetPc);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      count_q     <= '0;
      widx_q      <= '0;
      loaded_q    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      fetch_rst_q <= 1'b1;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      count_q     <= count_d;
      widx_q      <= widx_d;
      loaded_q    <= loaded_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      fetch_rst_q <= fetch_rst_d;
      live_q      <= 1'b1;
    end
  end

  // we_q and the assembler's pulse coincide; we_q is the one tied to the FSM.
  logic unused_word_valid;
  assign unused_word_valid = asm_word_valid;

  assign o_cmd_ready    = live_q && (state_q != StResetPc) && (state_q != StStep);
  assign o_stall        = (state_q == StRun) ? at_last : (state_q != StStep);
  assign o_imem_we      = we_q;
  assign o_imem_addr    = addr_q;
  assign o_imem_wdata   = asm_word;
  assign o_fetch_rst    = fetch_rst_q;
  assign o_state        = state_q;
  assign o_loaded_count = loaded_q;

endmodule
